// File: rtl/fp_adder_pkg.sv
// Shared floating-point adder types and widths.
// Defaults correspond to IEEE single precision with a hidden bit.
package fp_adder_pkg;

  localparam int MANTISSA_N = 24;
  localparam int EXP_N      = 8;
  localparam int GRS_N      = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    SHIFT   = 2'd2,
    DONE    = 2'd3
  } align_state_t;

endpackage

// File: rtl/mantissa_aligner.sv
// Orders two operands by magnitude and right-shifts the smaller mantissa (with sticky) to the larger exponent.
// Latency 2 cycles, or diff+2 while shifting; inReady only in IDLE; the result is held in DONE until outReady.
module mantissa_aligner #(
  parameter int MANTISSA_N = 24,
  parameter int EXP_N      = 8
) (
  input  logic                    Clock,
  input  logic                    ResetN,
  input  logic                    inValid,
  output logic                    inReady,
  input  logic                    signA,
  input  logic                    signB,
  input  logic [EXP_N-1:0]        expA,
  input  logic [EXP_N-1:0]        expB,
  input  logic [MANTISSA_N-1:0]   mantA,
  input  logic [MANTISSA_N-1:0]   mantB,
  output logic                    outValid,
  input  logic                    outReady,
  output logic                    bigSign,
  output logic                    smallSign,
  output logic [EXP_N-1:0]        alignedExp,
  output logic [MANTISSA_N+2:0]   bigMant,
  output logic [MANTISSA_N+2:0]   smallMant,
  output logic                    swapped
);
  import fp_adder_pkg::*;

  localparam int          W          = MANTISSA_N + GRS_N;
  localparam int unsigned FLUSH_DIFF = W;

  align_state_t state, state_nxt;

  logic                  a_sign, b_sign;
  logic [EXP_N-1:0]      a_exp, b_exp;
  logic [MANTISSA_N-1:0] a_mant, b_mant;
  logic [EXP_N-1:0]      count;
  logic [EXP_N-1:0]      diff;

  logic                  a_big;
  logic [EXP_N-1:0]      big_exp_c, small_exp_c, diff_c;
  logic [MANTISSA_N-1:0] big_mant_c, small_mant_c;
  logic                  flush_c;

  // Ordering guarantees big_exp_c >= small_exp_c, so diff_c cannot wrap.
  always_comb begin
    a_big        = (a_exp > b_exp) || ((a_exp == b_exp) && (a_mant >= b_mant));
    big_exp_c    = a_big ? a_exp  : b_exp;
    small_exp_c  = a_big ? b_exp  : a_exp;
    big_mant_c   = a_big ? a_mant : b_mant;
    small_mant_c = a_big ? b_mant : a_mant;
    diff_c       = big_exp_c - small_exp_c;
    flush_c      = 32'(diff_c) >= FLUSH_DIFF;
  end

  assign inReady  = (state == IDLE);
  assign outValid = (state == DONE);

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (inValid) state_nxt = COMPARE;
      COMPARE: state_nxt = ((diff_c == '0) || flush_c) ? DONE : SHIFT;
      SHIFT:   if (count == {{(EXP_N-1){1'b0}}, 1'b1}) state_nxt = DONE;
      DONE:    if (outReady) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      a_sign     <= 1'b0;
      b_sign     <= 1'b0;
      a_exp      <= '0;
      b_exp      <= '0;
      a_mant     <= '0;
      b_mant     <= '0;
      count      <= '0;
      diff       <= '0;
      bigSign    <= 1'b0;
      smallSign  <= 1'b0;
      alignedExp <= '0;
      bigMant    <= '0;
      smallMant  <= '0;
      swapped    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (inValid) begin
            a_sign <= signA;
            b_sign <= signB;
            a_exp  <= expA;
            b_exp  <= expB;
            a_mant <= mantA;
            b_mant <= mantB;
          end
        end
        COMPARE: begin
          bigSign    <= a_big ? a_sign : b_sign;
          smallSign  <= a_big ? b_sign : a_sign;
          alignedExp <= big_exp_c;
          swapped    <= ~a_big;
          diff       <= diff_c;
          bigMant    <= {big_mant_c, {GRS_N{1'b0}}};
          if (flush_c) begin
            // Everything shifts out; only the sticky bit survives.
            smallMant <= {{(W-1){1'b0}}, |small_mant_c};
            count     <= '0;
          end else begin
            smallMant <= {small_mant_c, {GRS_N{1'b0}}};
            count     <= diff_c;
          end
        end
        SHIFT: begin
          smallMant <= {1'b0, smallMant[W-1:2], smallMant[1] | smallMant[0]};
          count     <= count - 1'b1;
        end
        DONE: ;
        default: ;
      endcase
    end
  end

endmodule
